// File: rtl/ct_mmu_pkg.sv
// Shared MMU definitions: page-size encodings, default field widths and the
// helper that turns a page size into the number of VPN/PPN bits it passes through.
package ct_mmu_pkg;

    typedef enum logic [1:0] {
        PGS_4K  = 2'd0,
        PGS_2M  = 2'd1,
        PGS_1G  = 2'd2,
        PGS_RSV = 2'd3
    } pgs_e;

    localparam int DEF_VPN_WIDTH  = 27;
    localparam int DEF_PPN_WIDTH  = 28;
    localparam int DEF_FLG_WIDTH  = 14;
    localparam int DEF_ASID_WIDTH = 16;
    localparam int DEF_LVL_WIDTH  = 9;

    // Low address bits that bypass translation for a given page size.
    function automatic int pgs_skip(input logic [1:0] pgs, input int lvl);
        case (pgs)
            PGS_2M:  return lvl;
            PGS_1G:  return 2 * lvl;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/ct_mmu_dutlb_pgs_entry.sv
// One uTLB entry: storage plus per-port lookup comparators and the
// refill-match / invalidate-match terms the array needs for victim and flush.
module ct_mmu_dutlb_pgs_entry
    import ct_mmu_pkg::*;
#(
    parameter int PORT_NUM   = 2,
    parameter int VPN_WIDTH  = DEF_VPN_WIDTH,
    parameter int PPN_WIDTH  = DEF_PPN_WIDTH,
    parameter int FLG_WIDTH  = DEF_FLG_WIDTH,
    parameter int ASID_WIDTH = DEF_ASID_WIDTH,
    parameter int LVL_WIDTH  = DEF_LVL_WIDTH
) (
    input  logic                          utlb_entry_clk,
    input  logic                          cpurst_b,
    input  logic                          wr_en_i,
    input  logic                          clr_i,
    input  logic [VPN_WIDTH-1:0]          upd_vpn_i,
    input  logic [PPN_WIDTH-1:0]          upd_ppn_i,
    input  logic [FLG_WIDTH-1:0]          upd_flg_i,
    input  logic [ASID_WIDTH-1:0]         upd_asid_i,
    input  logic                          upd_g_i,
    input  logic [1:0]                    upd_pgs_i,
    input  logic [PORT_NUM*VPN_WIDTH-1:0] req_vpn_i,
    input  logic [ASID_WIDTH-1:0]         req_asid_i,
    input  logic [VPN_WIDTH-1:0]          inv_vpn_i,
    input  logic [ASID_WIDTH-1:0]         inv_asid_i,
    output logic                          vld_o,
    output logic [PPN_WIDTH-1:0]          ppn_o,
    output logic [FLG_WIDTH-1:0]          flg_o,
    output logic [1:0]                    pgs_o,
    output logic [PORT_NUM-1:0]           hit_o,
    output logic                          upd_hit_o,
    output logic                          va_hit_o,
    output logic                          asid_hit_o
);

    logic                  vld_q;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [PPN_WIDTH-1:0]  ppn_q;
    logic [FLG_WIDTH-1:0]  flg_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  g_q;
    logic [1:0]            pgs_q;
    logic [VPN_WIDTH-1:0]  mask_s;

    // Stored page size decides which VPN bits take part in every compare.
    assign mask_s = {VPN_WIDTH{1'b1}} << pgs_skip(pgs_q, LVL_WIDTH);

    // Entry storage; a clear wins over a write, though the array never issues both.
    always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_q  <= 1'b0;
            vpn_q  <= '0;
            ppn_q  <= '0;
            flg_q  <= '0;
            asid_q <= '0;
            g_q    <= 1'b0;
            pgs_q  <= 2'd0;
        end else begin
            if (clr_i) begin
                vld_q <= 1'b0;
            end else if (wr_en_i) begin
                vld_q <= 1'b1;
            end else begin
                vld_q <= vld_q;
            end
            if (wr_en_i) begin
                vpn_q  <= upd_vpn_i;
                ppn_q  <= upd_ppn_i;
                flg_q  <= upd_flg_i;
                asid_q <= upd_asid_i;
                g_q    <= upd_g_i;
                pgs_q  <= upd_pgs_i;
            end
        end
    end

    // Per-port lookup match against the shared current ASID.
    always_comb begin
        hit_o = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            hit_o[p] = vld_q
                     & (((req_vpn_i[p*VPN_WIDTH +: VPN_WIDTH] ^ vpn_q) & mask_s) == '0)
                     & (g_q | (asid_q == req_asid_i));
        end
    end

    // A refill hits this entry only if it would describe exactly the same mapping.
    assign upd_hit_o  = vld_q & (pgs_q == upd_pgs_i)
                      & (((upd_vpn_i ^ vpn_q) & mask_s) == '0)
                      & (g_q == upd_g_i) & (g_q | (asid_q == upd_asid_i));
    assign va_hit_o   = vld_q & (((inv_vpn_i ^ vpn_q) & mask_s) == '0);
    assign asid_hit_o = vld_q & ~g_q & (asid_q == inv_asid_i);

    assign vld_o = vld_q;
    assign ppn_o = ppn_q;
    assign flg_o = flg_q;
    assign pgs_o = pgs_q;

endmodule

// File: rtl/ct_mmu_dutlb_pgs_array.sv
// Multi-page-size data uTLB array: ENTRY_NUM entries, PORT_NUM one-cycle lookup
// ports, refill victim selection with round-robin fallback, and flush control.
module ct_mmu_dutlb_pgs_array
    import ct_mmu_pkg::*;
#(
    parameter int ENTRY_NUM  = 4,
    parameter int PORT_NUM   = 2,
    parameter int VPN_WIDTH  = DEF_VPN_WIDTH,
    parameter int PPN_WIDTH  = DEF_PPN_WIDTH,
    parameter int FLG_WIDTH  = DEF_FLG_WIDTH,
    parameter int ASID_WIDTH = DEF_ASID_WIDTH,
    parameter int LVL_WIDTH  = DEF_LVL_WIDTH
) (
    input  logic                          utlb_entry_clk,
    input  logic                          cpurst_b,
    input  logic [PORT_NUM-1:0]           req_vld,
    input  logic [PORT_NUM*VPN_WIDTH-1:0] req_vpn,
    input  logic [ASID_WIDTH-1:0]         req_asid,
    input  logic                          upd_vld,
    input  logic [VPN_WIDTH-1:0]          upd_vpn,
    input  logic [PPN_WIDTH-1:0]          upd_ppn,
    input  logic [FLG_WIDTH-1:0]          upd_flg,
    input  logic [ASID_WIDTH-1:0]         upd_asid,
    input  logic                          upd_g,
    input  logic [1:0]                    upd_pgs,
    input  logic                          inv_all,
    input  logic                          inv_asid_vld,
    input  logic [ASID_WIDTH-1:0]         inv_asid,
    input  logic                          inv_va_vld,
    input  logic [VPN_WIDTH-1:0]          inv_vpn,
    output logic [PORT_NUM-1:0]           rsp_vld,
    output logic [PORT_NUM-1:0]           rsp_hit,
    output logic [PORT_NUM-1:0]           rsp_multi_hit,
    output logic [PORT_NUM*PPN_WIDTH-1:0] rsp_ppn,
    output logic [PORT_NUM*FLG_WIDTH-1:0] rsp_flg,
    output logic [ENTRY_NUM-1:0]          entry_vld
);

    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam logic [PTR_W-1:0] RR_LAST = PTR_W'(ENTRY_NUM - 1);

    logic [ENTRY_NUM-1:0] e_vld_s;
    logic [ENTRY_NUM-1:0] e_upd_hit_s;
    logic [ENTRY_NUM-1:0] e_va_hit_s;
    logic [ENTRY_NUM-1:0] e_asid_hit_s;
    logic [ENTRY_NUM-1:0] e_wr_s;
    logic [ENTRY_NUM-1:0] e_clr_s;
    logic [PORT_NUM-1:0]  e_hit_s    [ENTRY_NUM];
    logic [PPN_WIDTH-1:0] e_ppn_s    [ENTRY_NUM];
    logic [FLG_WIDTH-1:0] e_flg_s    [ENTRY_NUM];
    logic [1:0]           e_pgs_s    [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] port_hit_s [PORT_NUM];

    logic             inv_any_s;
    logic             refill_s;
    logic             use_rr_s;
    logic [PTR_W-1:0] victim_s;
    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] rr_d;

    function automatic logic [PTR_W-1:0] lowest_set(input logic [ENTRY_NUM-1:0] vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
            if (vec[e]) idx = PTR_W'(e);
        end
        return idx;
    endfunction

    // Any invalidate suppresses a same-cycle refill; reserved page sizes are ignored.
    assign inv_any_s = inv_all | inv_asid_vld | inv_va_vld;
    assign refill_s  = upd_vld & ~inv_any_s & (upd_pgs != PGS_RSV);
    assign use_rr_s  = (&e_vld_s) & ~(|e_upd_hit_s);
    assign victim_s  = (|e_upd_hit_s) ? lowest_set(e_upd_hit_s) :
                       (~&e_vld_s)    ? lowest_set(~e_vld_s)    : rr_q;

    // Next round-robin pointer, advancing only when it picked the victim.
    always_comb begin
        if (refill_s && use_rr_s) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + PTR_W'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    for (genvar ge = 0; ge < ENTRY_NUM; ge++) begin : g_entry
        assign e_wr_s[ge]  = refill_s & (victim_s == PTR_W'(ge));
        assign e_clr_s[ge] = inv_all | (inv_any_s & (~inv_va_vld | e_va_hit_s[ge])
                                                  & (~inv_asid_vld | e_asid_hit_s[ge]));

        ct_mmu_dutlb_pgs_entry #(
            .PORT_NUM   (PORT_NUM),
            .VPN_WIDTH  (VPN_WIDTH),
            .PPN_WIDTH  (PPN_WIDTH),
            .FLG_WIDTH  (FLG_WIDTH),
            .ASID_WIDTH (ASID_WIDTH),
            .LVL_WIDTH  (LVL_WIDTH)
        ) u_entry (
            .utlb_entry_clk (utlb_entry_clk),
            .cpurst_b       (cpurst_b),
            .wr_en_i        (e_wr_s[ge]),
            .clr_i          (e_clr_s[ge]),
            .upd_vpn_i      (upd_vpn),
            .upd_ppn_i      (upd_ppn),
            .upd_flg_i      (upd_flg),
            .upd_asid_i     (upd_asid),
            .upd_g_i        (upd_g),
            .upd_pgs_i      (upd_pgs),
            .req_vpn_i      (req_vpn),
            .req_asid_i     (req_asid),
            .inv_vpn_i      (inv_vpn),
            .inv_asid_i     (inv_asid),
            .vld_o          (e_vld_s[ge]),
            .ppn_o          (e_ppn_s[ge]),
            .flg_o          (e_flg_s[ge]),
            .pgs_o          (e_pgs_s[ge]),
            .hit_o          (e_hit_s[ge]),
            .upd_hit_o      (e_upd_hit_s[ge]),
            .va_hit_o       (e_va_hit_s[ge]),
            .asid_hit_o     (e_asid_hit_s[ge])
        );
    end

    // Regroup entry-major hit bits into one hit vector per port.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            port_hit_s[p] = '0;
            for (int e = 0; e < ENTRY_NUM; e++) begin
                port_hit_s[p][e] = e_hit_s[e][p];
            end
        end
    end

    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_port
        logic [VPN_WIDTH-1:0] vpn_s;
        logic [PTR_W-1:0]     idx_s;
        logic [PPN_WIDTH-1:0] pmask_s;
        logic                 vld_q;
        logic                 hit_q;
        logic                 hit_d;
        logic                 multi_q;
        logic                 multi_d;
        logic [PPN_WIDTH-1:0] ppn_q;
        logic [PPN_WIDTH-1:0] ppn_d;
        logic [FLG_WIDTH-1:0] flg_q;
        logic [FLG_WIDTH-1:0] flg_d;

        assign vpn_s   = req_vpn[gp*VPN_WIDTH +: VPN_WIDTH];
        assign idx_s   = lowest_set(port_hit_s[gp]);
        assign pmask_s = {PPN_WIDTH{1'b1}} << pgs_skip(e_pgs_s[idx_s], LVL_WIDTH);

        // Lowest hitting entry supplies data; huge pages pass the page offset through.
        always_comb begin
            multi_d = req_vld[gp] & (|(port_hit_s[gp] & (port_hit_s[gp] - ENTRY_NUM'(1))));
            if (req_vld[gp] && (|port_hit_s[gp])) begin
                hit_d = 1'b1;
                ppn_d = (e_ppn_s[idx_s] & pmask_s) | (PPN_WIDTH'(vpn_s) & ~pmask_s);
                flg_d = e_flg_s[idx_s];
            end else begin
                hit_d = 1'b0;
                ppn_d = '0;
                flg_d = '0;
            end
        end

        // Response registers: one-cycle lookup latency.
        always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                vld_q   <= 1'b0;
                hit_q   <= 1'b0;
                multi_q <= 1'b0;
                ppn_q   <= '0;
                flg_q   <= '0;
            end else begin
                vld_q   <= req_vld[gp];
                hit_q   <= hit_d;
                multi_q <= multi_d;
                ppn_q   <= ppn_d;
                flg_q   <= flg_d;
            end
        end

        assign rsp_vld[gp]                           = vld_q;
        assign rsp_hit[gp]                           = hit_q;
        assign rsp_multi_hit[gp]                     = multi_q;
        assign rsp_ppn[gp*PPN_WIDTH +: PPN_WIDTH]    = ppn_q;
        assign rsp_flg[gp*FLG_WIDTH +: FLG_WIDTH]    = flg_q;
    end

    assign entry_vld = e_vld_s;

endmodule

// File: tb/tb_ct_mmu_dutlb_pgs_array.sv
// Bench for ct_mmu_dutlb_pgs_array: directed scenarios plus random traffic,
// checked every cycle against an array-of-entries reference model.
module tb_ct_mmu_dutlb_pgs_array;

    localparam int E  = 4;
    localparam int P  = 2;
    localparam int VW = 27;
    localparam int PW = 28;
    localparam int FW = 14;
    localparam int AW = 16;
    localparam int LW = 9;

    logic            clk;
    logic            rst_b;
    logic [P-1:0]    req_vld;
    logic [P*VW-1:0] req_vpn;
    logic [AW-1:0]   req_asid;
    logic            upd_vld;
    logic [VW-1:0]   upd_vpn;
    logic [PW-1:0]   upd_ppn;
    logic [FW-1:0]   upd_flg;
    logic [AW-1:0]   upd_asid;
    logic            upd_g;
    logic [1:0]      upd_pgs;
    logic            inv_all;
    logic            inv_asid_vld;
    logic [AW-1:0]   inv_asid;
    logic            inv_va_vld;
    logic [VW-1:0]   inv_vpn;
    logic [P-1:0]    rsp_vld;
    logic [P-1:0]    rsp_hit;
    logic [P-1:0]    rsp_multi_hit;
    logic [P*PW-1:0] rsp_ppn;
    logic [P*FW-1:0] rsp_flg;
    logic [E-1:0]    entry_vld;

    int errors = 0;
    int checks = 0;

    // Reference model: plain arrays describing each entry's mapping.
    bit              m_vld  [E];
    longint unsigned m_vpn  [E];
    longint unsigned m_ppn  [E];
    int unsigned     m_flg  [E];
    int unsigned     m_asid [E];
    bit              m_g    [E];
    int              m_pgs  [E];
    int              m_rr;

    bit              x_vld   [P];
    bit              x_hit   [P];
    bit              x_multi [P];
    longint unsigned x_ppn   [P];
    int unsigned     x_flg   [P];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ct_mmu_dutlb_pgs_array #(
        .ENTRY_NUM (E), .PORT_NUM (P), .VPN_WIDTH (VW), .PPN_WIDTH (PW),
        .FLG_WIDTH (FW), .ASID_WIDTH (AW), .LVL_WIDTH (LW)
    ) dut (
        .utlb_entry_clk (clk),
        .cpurst_b       (rst_b),
        .req_vld        (req_vld),
        .req_vpn        (req_vpn),
        .req_asid       (req_asid),
        .upd_vld        (upd_vld),
        .upd_vpn        (upd_vpn),
        .upd_ppn        (upd_ppn),
        .upd_flg        (upd_flg),
        .upd_asid       (upd_asid),
        .upd_g          (upd_g),
        .upd_pgs        (upd_pgs),
        .inv_all        (inv_all),
        .inv_asid_vld   (inv_asid_vld),
        .inv_asid       (inv_asid),
        .inv_va_vld     (inv_va_vld),
        .inv_vpn        (inv_vpn),
        .rsp_vld        (rsp_vld),
        .rsp_hit        (rsp_hit),
        .rsp_multi_hit  (rsp_multi_hit),
        .rsp_ppn        (rsp_ppn),
        .rsp_flg        (rsp_flg),
        .entry_vld      (entry_vld)
    );

    function automatic int page_shift(input int pgs);
        return (pgs == 1) ? LW : ((pgs == 2) ? 2 * LW : 0);
    endfunction

    function automatic logic [E-1:0] model_vec();
        logic [E-1:0] v;
        for (int e = 0; e < E; e++) v[e] = m_vld[e];
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vpn();
        return VW'(($urandom_range(0, 2) << (2 * LW)) | ($urandom_range(0, 1) << LW) | $urandom_range(0, 2));
    endfunction

    task automatic model_reset();
        for (int e = 0; e < E; e++) begin
            m_vld[e] = 1'b0; m_vpn[e] = 0; m_ppn[e] = 0; m_flg[e] = 0;
            m_asid[e] = 0; m_g[e] = 1'b0; m_pgs[e] = 0;
        end
        m_rr = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response for the request currently on the inputs, from pre-update state.
    task automatic predict();
        for (int p = 0; p < P; p++) begin
            longint unsigned vpn;
            int cnt, first, sh;
            vpn = 64'(req_vpn[p*VW +: VW]);
            cnt = 0;
            first = -1;
            for (int e = 0; e < E; e++) begin
                sh = page_shift(m_pgs[e]);
                if (m_vld[e] && (m_vpn[e] >> sh) == (vpn >> sh) &&
                    (m_g[e] || m_asid[e] == 32'(req_asid))) begin
                    if (first < 0) first = e;
                    cnt++;
                end
            end
            x_vld[p]   = req_vld[p];
            x_hit[p]   = req_vld[p] && (cnt > 0);
            x_multi[p] = req_vld[p] && (cnt > 1);
            if (x_hit[p]) begin
                sh = page_shift(m_pgs[first]);
                x_ppn[p] = ((m_ppn[first] >> sh) << sh) | (vpn % (64'd1 << sh));
                x_flg[p] = m_flg[first];
            end else begin
                x_ppn[p] = 0;
                x_flg[p] = 0;
            end
        end
    endtask

    // State change the clock edge must cause.
    task automatic model_update();
        if (inv_all || inv_asid_vld || inv_va_vld) begin
            for (int e = 0; e < E; e++) begin
                int sh;
                bit va_ok, as_ok;
                sh = page_shift(m_pgs[e]);
                va_ok = (m_vpn[e] >> sh) == (64'(inv_vpn) >> sh);
                as_ok = !m_g[e] && m_asid[e] == 32'(inv_asid);
                if (inv_all || ((!inv_va_vld || va_ok) && (!inv_asid_vld || as_ok))) m_vld[e] = 1'b0;
            end
        end else if (upd_vld && upd_pgs != 2'd3) begin
            int sh, victim;
            sh = page_shift(int'(upd_pgs));
            victim = -1;
            for (int e = 0; e < E; e++) begin
                if (victim < 0 && m_vld[e] && m_pgs[e] == int'(upd_pgs) &&
                    (m_vpn[e] >> sh) == (64'(upd_vpn) >> sh) && m_g[e] == upd_g &&
                    (upd_g || m_asid[e] == 32'(upd_asid))) victim = e;
            end
            for (int e = 0; e < E; e++) begin
                if (victim < 0 && !m_vld[e]) victim = e;
            end
            if (victim < 0) begin
                victim = m_rr;
                m_rr = (m_rr + 1) % E;
            end
            m_vld[victim]  = 1'b1;
            m_vpn[victim]  = 64'(upd_vpn);
            m_ppn[victim]  = 64'(upd_ppn);
            m_flg[victim]  = 32'(upd_flg);
            m_asid[victim] = 32'(upd_asid);
            m_g[victim]    = upd_g;
            m_pgs[victim]  = int'(upd_pgs);
        end
    endtask

    // One clock: predict, let the edge happen, then compare every output.
    task automatic step();
        predict();
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int p = 0; p < P; p++) begin
            chk($sformatf("rsp_vld[%0d]", p),       64'(rsp_vld[p]),       64'(x_vld[p]));
            chk($sformatf("rsp_hit[%0d]", p),       64'(rsp_hit[p]),       64'(x_hit[p]));
            chk($sformatf("rsp_multi_hit[%0d]", p), 64'(rsp_multi_hit[p]), 64'(x_multi[p]));
            chk($sformatf("rsp_ppn[%0d]", p),       64'(rsp_ppn[p*PW +: PW]), x_ppn[p]);
            chk($sformatf("rsp_flg[%0d]", p),       64'(rsp_flg[p*FW +: FW]), 64'(x_flg[p]));
        end
        chk("entry_vld", 64'(entry_vld), 64'(model_vec()));
    endtask

    task automatic idle_inputs();
        req_vld = '0; req_vpn = '0; req_asid = '0;
        upd_vld = 1'b0; upd_vpn = '0; upd_ppn = '0; upd_flg = '0;
        upd_asid = '0; upd_g = 1'b0; upd_pgs = 2'd0;
        inv_all = 1'b0; inv_asid_vld = 1'b0; inv_asid = '0;
        inv_va_vld = 1'b0; inv_vpn = '0;
    endtask

    task automatic refill(input logic [VW-1:0] vpn, input logic [PW-1:0] ppn,
                          input logic [FW-1:0] flg, input logic [AW-1:0] asid,
                          input logic g, input logic [1:0] pgs);
        upd_vld = 1'b1; upd_vpn = vpn; upd_ppn = ppn; upd_flg = flg;
        upd_asid = asid; upd_g = g; upd_pgs = pgs;
        step();
        upd_vld = 1'b0;
    endtask

    task automatic lookup(input int p, input logic [VW-1:0] vpn, input logic [AW-1:0] asid);
        req_vld = '0;
        req_vld[p] = 1'b1;
        req_vpn[p*VW +: VW] = vpn;
        req_asid = asid;
        step();
        req_vld = '0;
    endtask

    task automatic flush_all();
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_b = 1'b0;
        #1;
        chk("reset rsp_vld", 64'(rsp_vld), 64'd0);
        chk("reset rsp_ppn", 64'(rsp_ppn), 64'd0);
        chk("reset entry_vld", 64'(entry_vld), 64'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        step();

        // 1G translation with offset pass-through; port 1 misses on a foreign ASID.
        refill(27'h3480000, 28'hAB00000, 14'h0155, 16'd5, 1'b0, 2'd2);
        req_vld = 2'b11;
        req_vpn[VW-1:0] = 27'h3492345;
        req_vpn[2*VW-1:VW] = 27'h3492345;
        req_asid = 16'd5;
        step();
        chk("1g hit", 64'(rsp_hit[0]), 64'd1);
        chk("1g ppn", 64'(rsp_ppn[PW-1:0]), 64'h0AB12345);
        lookup(1, 27'h3492345, 16'd6);
        chk("1g wrong asid", 64'(rsp_hit[1]), 64'd0);

        // Round-robin replacement once the array is full.
        flush_all();
        for (int i = 0; i < 5; i++) begin
            refill(VW'(27'h100 + i), PW'(28'h1000 + i), 14'h0003, 16'd1, 1'b0, 2'd0);
        end
        chk("rr full", 64'(entry_vld), 64'hF);
        chk("rr ptr model", 64'(m_rr), 64'd1);
        lookup(0, 27'h100, 16'd1);
        chk("rr evicted miss", 64'(rsp_hit[0]), 64'd0);
        lookup(0, 27'h104, 16'd1);
        chk("rr newest hit", 64'(rsp_hit[0]), 64'd1);

        // ASID invalidate spares the global entry.
        flush_all();
        refill(27'h200, 28'h2000, 14'h0001, 16'd3, 1'b0, 2'd0);
        refill(27'h201, 28'h2001, 14'h0001, 16'd3, 1'b1, 2'd0);
        chk("asid pre", 64'(entry_vld), 64'h3);
        inv_asid_vld = 1'b1; inv_asid = 16'd3;
        step();
        inv_asid_vld = 1'b0;
        chk("asid keep global", 64'(entry_vld), 64'h2);

        // Refill colliding with a VA invalidate is dropped.
        flush_all();
        refill(27'h300, 28'h3000, 14'h0001, 16'd1, 1'b0, 2'd0);
        upd_vld = 1'b1; upd_vpn = 27'h301; upd_pgs = 2'd0; upd_asid = 16'd1;
        inv_va_vld = 1'b1; inv_vpn = 27'h300;
        step();
        idle_inputs();
        chk("inv beats refill", 64'(entry_vld), 64'h0);

        // Overlapping 2M and 4K entries: multi-hit, lower index supplies data.
        refill(27'h0000A00, 28'h0555E00, 14'h0011, 16'd2, 1'b0, 2'd1);
        refill(27'h0000A05, 28'h0777777, 14'h0022, 16'd2, 1'b0, 2'd0);
        lookup(1, 27'h0000A05, 16'd2);
        chk("multi hit", 64'(rsp_multi_hit[1]), 64'd1);
        chk("multi ppn", 64'(rsp_ppn[2*PW-1:PW]), 64'h0555E05);
        refill(27'h0000B00, 28'h0123456, 14'h0033, 16'd2, 1'b0, 2'd3);
        chk("reserved pgs dropped", 64'(entry_vld), 64'h3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r;
            idle_inputs();
            req_vld = P'($urandom_range(0, 3));
            for (int p = 0; p < P; p++) req_vpn[p*VW +: VW] = rnd_vpn();
            req_asid = AW'($urandom_range(1, 2));
            r = $urandom_range(0, 99);
            if (r < 35) begin
                upd_vld = 1'b1; upd_vpn = rnd_vpn(); upd_ppn = PW'($urandom);
                upd_flg = FW'($urandom); upd_asid = AW'($urandom_range(1, 2));
                upd_g = ($urandom_range(0, 3) == 0); upd_pgs = 2'($urandom_range(0, 3));
            end
            inv_vpn = rnd_vpn();
            inv_asid = AW'($urandom_range(1, 2));
            inv_va_vld   = (r >= 30 && r < 40) || (r >= 46 && r < 50);
            inv_asid_vld = (r >= 40 && r < 50);
            inv_all      = (r == 99);
            step();
        end
        idle_inputs();

        // Reset while a request is in flight.
        refill(27'h500, 28'h5000, 14'h0005, 16'd1, 1'b0, 2'd0);
        req_vld = 2'b11;
        req_vpn[VW-1:0] = 27'h500;
        req_asid = 16'd1;
        #2;
        rst_b = 1'b0;
        #1;
        chk("mid reset rsp_vld", 64'(rsp_vld), 64'd0);
        chk("mid reset rsp_hit", 64'(rsp_hit), 64'd0);
        chk("mid reset rsp_multi_hit", 64'(rsp_multi_hit), 64'd0);
        chk("mid reset rsp_ppn", 64'(rsp_ppn), 64'd0);
        chk("mid reset rsp_flg", 64'(rsp_flg), 64'd0);
        chk("mid reset entry_vld", 64'(entry_vld), 64'd0);
        req_vld = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        step();
        chk("post reset no rsp", 64'(rsp_vld), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
